// File: rtl/list_collector.sv
// Collects a valid/ready element stream into a zero-padded LENGTH-slot list for the summer
// and returns the sum on a valid/ready port. Define LIST_COLLECTOR_COUNT_EN to add res_count.
module list_collector #(
   parameter  int DATA_WIDTH = 32,
   parameter  int LENGTH     = 8,
   localparam int CNT_WIDTH  = $clog2(LENGTH + 1),
   localparam int SUM_WIDTH  = $clog2(LENGTH) + DATA_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [DATA_WIDTH-1:0]               in_data,
   input  logic                                in_valid,
   input  logic                                in_last,
   output logic                                in_ready,
   output logic [LENGTH-1:0][DATA_WIDTH-1:0]   data_out,
   output logic                                sum_en,
   input  logic                                sum_done,
   input  logic [SUM_WIDTH-1:0]                sum_result,
   output logic [SUM_WIDTH-1:0]                res_data,
   output logic                                res_valid,
`ifdef LIST_COLLECTOR_COUNT_EN
   output logic [CNT_WIDTH-1:0]                res_count,
`endif
   input  logic                                res_ready
);

   typedef enum logic [1:0] {S_FILL, S_SUM, S_RESULT} state_t;

   state_t                            state_q, state_d;
   logic [CNT_WIDTH-1:0]              wr_ptr_q, wr_ptr_d;
   logic [LENGTH-1:0][DATA_WIDTH-1:0] slots_q, slots_d;
   logic                              sum_en_q, sum_en_d;
   logic [SUM_WIDTH-1:0]              res_data_q, res_data_d;
   logic                              res_valid_q, res_valid_d;
`ifdef LIST_COLLECTOR_COUNT_EN
   logic [CNT_WIDTH-1:0]              count_q, count_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FILL;
         wr_ptr_q    <= '0;
         slots_q     <= '0;
         sum_en_q    <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
`ifdef LIST_COLLECTOR_COUNT_EN
         count_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         slots_q     <= slots_d;
         sum_en_q    <= sum_en_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
`ifdef LIST_COLLECTOR_COUNT_EN
         count_q     <= count_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      slots_d     = slots_q;
      sum_en_d    = sum_en_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
`ifdef LIST_COLLECTOR_COUNT_EN
      count_d     = count_q;
`endif
      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               for (int i = 0; i < LENGTH; i++) begin
                  if (wr_ptr_q == CNT_WIDTH'(i)) slots_d[i] = in_data;
               end
               wr_ptr_d = wr_ptr_q + CNT_WIDTH'(1);
               // in_last on the final slot is one termination, not two
               if (in_last || (wr_ptr_q == CNT_WIDTH'(LENGTH - 1))) begin
                  state_d  = S_SUM;
                  sum_en_d = 1'b1;
               end
            end
         end
         S_SUM: begin
            if (sum_done) begin
               res_data_d  = sum_result;
               res_valid_d = 1'b1;
               sum_en_d    = 1'b0;
               state_d     = S_RESULT;
`ifdef LIST_COLLECTOR_COUNT_EN
               count_d     = wr_ptr_q;
`endif
            end
         end
         S_RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               slots_d     = '0;
               wr_ptr_d    = '0;
               state_d     = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   assign in_ready  = (state_q == S_FILL);
   assign data_out  = slots_q;
   assign sum_en    = sum_en_q;
   assign res_data  = res_data_q;
   assign res_valid = res_valid_q;
`ifdef LIST_COLLECTOR_COUNT_EN
   assign res_count = count_q;
`endif

endmodule

// File: tb/tb_list_collector.sv
// Testbench for list_collector: bench-side summer stub (combinational or delayed) plus a
// queue-based reference model of the list contents, sum and element count.
`timescale 1ns/1ps
module tb_list_collector;
   localparam int DW = 32;
   localparam int L  = 8;
   localparam int CW = $clog2(L + 1);
   localparam int SW = $clog2(L) + DW;
   typedef logic [L-1:0][DW-1:0] slots_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_valid, in_last, in_ready;
   slots_t        data_out;
   logic          sum_en, sum_done;
   logic [SW-1:0] sum_result, res_data;
   logic          res_valid, res_ready;
`ifdef LIST_COLLECTOR_COUNT_EN
   logic [CW-1:0] res_count;
`endif

   int total = 0;
   int bad   = 0;

   bit comb_mode;
   int seq_delay;
   int seq_cnt;
   logic [DW-1:0] lst[$];

   always #5 clk = ~clk;

   list_collector dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .data_out(data_out), .sum_en(sum_en), .sum_done(sum_done), .sum_result(sum_result),
      .res_data(res_data), .res_valid(res_valid),
`ifdef LIST_COLLECTOR_COUNT_EN
      .res_count(res_count),
`endif
      .res_ready(res_ready)
   );

   // summer stub: adds whatever the collector presents, finishes immediately or after seq_delay cycles
   always @(posedge clk) seq_cnt <= sum_en ? seq_cnt + 1 : 0;
   assign sum_done = sum_en && (comb_mode || (seq_cnt >= seq_delay));
   always_comb begin
      sum_result = '0;
      for (int i = 0; i < L; i++) sum_result = sum_result + SW'(data_out[i]);
   end

   function automatic slots_t model_slots();
      slots_t v;
      v = '0;
      foreach (lst[i]) v[i] = lst[i];
      return v;
   endfunction

   function automatic logic [SW-1:0] model_sum();
      logic [SW-1:0] s;
      s = '0;
      foreach (lst[i]) s = s + SW'(lst[i]);
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_elem(input logic [DW-1:0] d, input logic last);
      int w;
      w = 0;
      in_valid = 1'b1; in_data = d; in_last = last;
      while (in_ready !== 1'b1 && w < 200) begin step(); w++; end
      if (in_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL send_timeout in_ready=%b want=1", in_ready);
      end
      step();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drive_list(input bit use_last, input int gap_pct);
      for (int i = 0; i < lst.size(); i++) begin
         while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin in_valid = 1'b0; step(); end
         send_elem(lst[i], (i == lst.size() - 1) && (use_last || lst.size() < L));
      end
   endtask

   task automatic wait_result(output int cyc);
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 500) begin step(); cyc++; end
      if (res_valid !== 1'b1) begin
         total++; bad++;
         $display("FAIL result_timeout res_valid=%b want=1", res_valid);
      end
   endtask

   task automatic accept_result();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ready = 1'b0;
      comb_mode = 1'b1; seq_delay = 0;
      #13;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (sum_en !== 1'b0) begin bad++; $display("FAIL reset_sum_en got=%b want=0", sum_en); end
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
      total++; if (res_data !== '0) begin bad++; $display("FAIL reset_res_data got=%h want=0", res_data); end
      total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data_out got=%h want=0", data_out); end
`ifdef LIST_COLLECTOR_COUNT_EN
      total++; if (res_count !== '0) begin bad++; $display("FAIL reset_res_count got=%0d want=0", res_count); end
`endif
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_full_list();
      comb_mode = 1'b1;
      lst = {};
      for (int i = 1; i <= L; i++) lst.push_back(DW'(i));
      drive_list(1'b1, 0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
      total++; if (sum_en !== 1'b1) begin bad++; $display("FAIL full_sum_en got=%b want=1", sum_en); end
      total++; if (data_out !== model_slots()) begin bad++; $display("FAIL full_slots got=%h want=%h", data_out, model_slots()); end
      step();
      total++; if (sum_en !== 1'b0) begin bad++; $display("FAIL full_sum_en_drop got=%b want=0", sum_en); end
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL full_res_valid got=%b want=1", res_valid); end
      total++; if (res_data !== SW'(36)) begin bad++; $display("FAIL full_res_data got=%0d want=36", res_data); end
`ifdef LIST_COLLECTOR_COUNT_EN
      total++; if (res_count !== CW'(L)) begin bad++; $display("FAIL full_res_count got=%0d want=%0d", res_count, L); end
`endif
      repeat (3) begin
         step();
         total++; if (res_valid !== 1'b1 || res_data !== SW'(36)) begin
            bad++; $display("FAIL full_hold got=%b/%0d want=1/36", res_valid, res_data);
         end
      end
      accept_result();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL full_handshake_valid got=%b want=0", res_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_back_to_fill got=%b want=1", in_ready); end
      total++; if (data_out !== '0) begin bad++; $display("FAIL full_clear got=%h want=0", data_out); end
   endtask

   task automatic test_short_list();
      comb_mode = 1'b1;
      lst = {32'd5, 32'd7, 32'd9};
      drive_list(1'b1, 0);
      total++; if (data_out !== model_slots()) begin bad++; $display("FAIL short_slots got=%h want=%h", data_out, model_slots()); end
      step();
      total++; if (res_data !== SW'(21)) begin bad++; $display("FAIL short_res_data got=%0d want=21", res_data); end
`ifdef LIST_COLLECTOR_COUNT_EN
      total++; if (res_count !== CW'(3)) begin bad++; $display("FAIL short_res_count got=%0d want=3", res_count); end
`endif
      accept_result();
   endtask

   task automatic test_max();
      int cyc;
      comb_mode = 1'b1;
      lst = {};
      repeat (L) lst.push_back('1);
      drive_list(1'b1, 0);
      wait_result(cyc);
      total++; if (res_data !== SW'(35'h7_FFFF_FFF8)) begin bad++; $display("FAIL max_res_data got=%h want=7fffffff8", res_data); end
      accept_result();
   endtask

   task automatic test_seq_summer();
      slots_t snap;
      int cyc, n;
      comb_mode = 1'b0; seq_delay = 8;
      n = $urandom_range(2, L);
      lst = {};
      repeat (n) lst.push_back($urandom);
      drive_list($urandom_range(1), 0);
      snap = model_slots();
      total++; if (sum_en !== 1'b1) begin bad++; $display("FAIL seq_sum_en got=%b want=1", sum_en); end
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 100) begin
         in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom_range(1));
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL seq_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
         total++; if (data_out !== snap) begin bad++; $display("FAIL seq_stable cyc=%0d got=%h want=%h", cyc, data_out, snap); end
         step(); cyc++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      total++; if (cyc !== seq_delay + 1) begin bad++; $display("FAIL seq_dwell got=%0d want=%0d", cyc, seq_delay + 1); end
      total++; if (res_data !== model_sum()) begin bad++; $display("FAIL seq_res_data got=%h want=%h", res_data, model_sum()); end
      accept_result();
      repeat (5) begin
         step();
         total++; if (res_valid !== 1'b0 || sum_en !== 1'b0) begin
            bad++; $display("FAIL seq_single_result got=%b/%b want=0/0", res_valid, sum_en);
         end
      end
      total++; if (data_out !== '0) begin bad++; $display("FAIL seq_clear got=%h want=0", data_out); end
      comb_mode = 1'b1; seq_delay = 0;
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] exp_a;
      logic [DW-1:0] b0, b1;
      comb_mode = 1'b1;
      lst = {};
      repeat (L) lst.push_back($urandom | 32'h1);
      drive_list(1'b0, 0);
      step();
      exp_a = model_sum();
      b0 = $urandom; b1 = $urandom;
      in_valid = 1'b1; in_data = b0; in_last = 1'b0; res_ready = 1'b0;
      repeat (5) begin
         total++; if (res_valid !== 1'b1 || res_data !== exp_a || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold got=%b/%h/%b want=1/%h/0", res_valid, res_data, in_ready, exp_a);
         end
         step();
      end
      accept_result();
      total++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b want=1/0", in_ready, res_valid); end
      step();
      total++; if (data_out[0] !== b0) begin bad++; $display("FAIL bp_first_accept got=%h want=%h", data_out[0], b0); end
      lst = {b0, b1};
      send_elem(b1, 1'b1);
      total++; if (data_out !== model_slots()) begin bad++; $display("FAIL bp_no_stale got=%h want=%h", data_out, model_slots()); end
      step();
      total++; if (res_data !== model_sum()) begin bad++; $display("FAIL bp_second_sum got=%h want=%h", res_data, model_sum()); end
`ifdef LIST_COLLECTOR_COUNT_EN
      total++; if (res_count !== CW'(2)) begin bad++; $display("FAIL bp_res_count got=%0d want=2", res_count); end
`endif
      accept_result();
   endtask

   task automatic test_reset_mid();
      comb_mode = 1'b1;
      for (int i = 0; i < 4; i++) send_elem($urandom | 32'h1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1 || sum_en !== 1'b0 || res_valid !== 1'b0) begin
         bad++; $display("FAIL rstmid_ctrl got=%b/%b/%b want=1/0/0", in_ready, sum_en, res_valid);
      end
      total++; if (data_out !== '0) begin bad++; $display("FAIL rstmid_slots got=%h want=0", data_out); end
      @(negedge clk); rst_n = 1'b1;
      step();
      lst = {32'd10, 32'd20};
      drive_list(1'b1, 0);
      total++; if (data_out !== model_slots()) begin bad++; $display("FAIL rstmid_list got=%h want=%h", data_out, model_slots()); end
      step();
      total++; if (res_data !== SW'(30)) begin bad++; $display("FAIL rstmid_res_data got=%0d want=30", res_data); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (res_valid !== 1'b0 || res_data !== '0) begin
         bad++; $display("FAIL rstmid_pending got=%b/%h want=0/0", res_valid, res_data);
      end
`ifdef LIST_COLLECTOR_COUNT_EN
      total++; if (res_count !== '0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", res_count); end
`endif
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_random();
      int cyc, n;
      for (int it = 0; it < 25; it++) begin
         comb_mode = 1'($urandom_range(1));
         seq_delay = $urandom_range(0, 6);
         n = $urandom_range(1, L);
         lst = {};
         repeat (n) lst.push_back($urandom);
         drive_list($urandom_range(1), 30);
         total++; if (sum_en !== 1'b1 || in_ready !== 1'b0 || data_out !== model_slots()) begin
            bad++; $display("FAIL rand_list it=%0d got=%b/%b/%h want=1/0/%h", it, sum_en, in_ready, data_out, model_slots());
         end
         wait_result(cyc);
         repeat ($urandom_range(0, 3)) step();
         total++; if (res_valid !== 1'b1 || res_data !== model_sum()) begin
            bad++; $display("FAIL rand_sum it=%0d got=%b/%h want=1/%h", it, res_valid, res_data, model_sum());
         end
`ifdef LIST_COLLECTOR_COUNT_EN
         total++; if (res_count !== CW'(n)) begin bad++; $display("FAIL rand_count it=%0d got=%0d want=%0d", it, res_count, n); end
`endif
         accept_result();
      end
      comb_mode = 1'b1;
   endtask

   initial begin
      test_reset();
      test_full_list();
      test_short_list();
      test_max();
      test_seq_summer();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
